// File: rtl/rf_wb_sched_pkg.sv
// Shared widths and requester IDs for the register-file writeback scheduler.
// The width defines are guarded so an existing project-wide definition takes precedence.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package rf_wb_sched_pkg;

  localparam int unsigned NUM_REGS = 1 << `RF_ADDR_WIDTH;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register moves only when a grant is given.
// Every grant is a completed handshake, because a grant is only ever raised on an active request.
module rr_arb2
  import rf_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_id_e last_grant;

  // NOTE: give every combinational output a default first so no path infers a latch.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == WB_LSU) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= WB_LSU;
    else if (gnt[0]) last_grant <= WB_ALU;
    else if (gnt[1]) last_grant <= WB_LSU;
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Shares the single register-file write port between the ALU and load-unit writebacks
// and keeps a busy scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [`RF_ADDR_WIDTH-1:0] issue_rd,
  input  logic [`RF_ADDR_WIDTH-1:0] issue_rs1,
  input  logic [`RF_ADDR_WIDTH-1:0] issue_rs2,
  output logic                      issue_ready,
  input  logic                      wb0_valid,
  input  logic [`RF_ADDR_WIDTH-1:0] wb0_addr,
  input  logic [`WORD_WIDTH-1:0]    wb0_data,
  input  logic                      wb1_valid,
  input  logic [`RF_ADDR_WIDTH-1:0] wb1_addr,
  input  logic [`WORD_WIDTH-1:0]    wb1_data,
  output logic                      wb0_ready,
  output logic                      wb1_ready,
  output logic                      rf_we,
  output logic [`RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [`WORD_WIDTH-1:0]    rf_wdata,
  output logic                      idle
);

  logic [1:0]          gnt;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1_valid, wb0_valid}),
    .gnt (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    if (gnt[0]) begin
      rf_waddr = wb0_addr;
      rf_wdata = wb0_data;
    end else if (gnt[1]) begin
      rf_waddr = wb1_addr;
      rf_wdata = wb1_data;
    end
  end

  // x0 writebacks still handshake but never reach the register file.
  assign rf_we = (|gnt) && (rf_waddr != '0);

  // busy[0] is held at 0, so x0 operands never stall; no bypass from this cycle's clear.
  assign issue_ready = !rst && issue_valid &&
                       !busy[issue_rs1] && !busy[issue_rs2] && !busy[issue_rd];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_ready) set_vec[issue_rd] = 1'b1;
    if (|gnt)        clr_vec[rf_waddr] = 1'b1;
  end

  // Set is applied after clear so a same-cycle issue to a retiring rd keeps it busy.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= ((busy & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
  end

  assign idle = (busy == '0);

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched with a small behavioural register file
// attached to the rf_* port, so x0 protection and write data can be observed.
`timescale 1ns/1ps
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        idle;

  int errors = 0;
  int checks = 0;

  // Raw storage with no x0 protection of its own.
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_ready (issue_ready),
    .wb0_valid   (wb0_valid),
    .wb0_addr    (wb0_addr),
    .wb0_data    (wb0_data),
    .wb1_valid   (wb1_valid),
    .wb1_addr    (wb1_addr),
    .wb1_data    (wb1_data),
    .wb0_ready   (wb0_ready),
    .wb1_ready   (wb1_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .idle        (idle)
  );

  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = 1'b1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  task automatic grants(input string tag, input logic g0, input logic g1);
    check({tag, "_wb0_ready"}, 32'(wb0_ready), 32'(g0));
    check({tag, "_wb1_ready"}, 32'(wb1_ready), 32'(g1));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rst = 1'b1;
    idle_inputs();
    cyc();

    // Outputs forced low while reset is held, even with requests present.
    wb0_valid = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h1111_1111;
    issue(5'd5, 5'd0, 5'd0);
    #1;
    grants("rst_hold", 1'b0, 1'b0);
    check("rst_hold_rf_we", 32'(rf_we), 32'd0);
    check("rst_hold_issue_ready", 32'(issue_ready), 32'd0);
    cyc();
    check("rst_idle", 32'(idle), 32'd1);

    // First issue after reset: rd=5 with x0 sources.
    rst = 1'b0;
    idle_inputs();
    issue(5'd5, 5'd0, 5'd0);
    #1;
    check("issue_rd5_ready", 32'(issue_ready), 32'd1);
    check("issue_rd5_rf_we", 32'(rf_we), 32'd0);
    cyc();
    check("busy5_idle", 32'(idle), 32'd0);

    // RAW stall on x5 while its writeback completes in the same cycle (no bypass).
    idle_inputs();
    issue(5'd6, 5'd5, 5'd0);
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEAD_BEEF;
    #1;
    check("raw_stall", 32'(issue_ready), 32'd0);
    grants("wb5", 1'b1, 1'b0);
    check("wb5_rf_we", 32'(rf_we), 32'd1);
    check("wb5_waddr", 32'(rf_waddr), 32'd5);
    check("wb5_wdata", rf_wdata, 32'hDEAD_BEEF);
    cyc();
    wb0_valid = 1'b0;
    #1;
    check("raw_release", 32'(issue_ready), 32'd1);
    check("rf_x5", rf_mem[5], 32'hDEAD_BEEF);
    cyc();
    check("busy6_idle", 32'(idle), 32'd0);

    // WAW stall on busy rd, then retire x6 through the load unit.
    idle_inputs();
    issue(5'd6, 5'd0, 5'd0);
    wb1_valid = 1'b1; wb1_addr = 5'd6; wb1_data = 32'h0000_0066;
    #1;
    check("waw_stall", 32'(issue_ready), 32'd0);
    grants("wb6", 1'b0, 1'b1);
    cyc();
    idle_inputs();
    #1;
    check("wb6_idle", 32'(idle), 32'd1);

    // Fresh reset, then contention: wb0 first, then alternating.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'hA0A0_0001;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'hB0B0_0002;
    #1;
    grants("rr_c0", 1'b1, 1'b0);
    check("rr_c0_waddr", 32'(rf_waddr), 32'd1);
    cyc();
    grants("rr_c1", 1'b0, 1'b1);
    check("rr_c1_wdata", rf_wdata, 32'hB0B0_0002);
    cyc();
    grants("rr_c2", 1'b1, 1'b0);
    cyc();
    grants("rr_c3", 1'b0, 1'b1);
    check("rr_idle", 32'(idle), 32'd1);
    cyc();
    check("rf_x2", rf_mem[2], 32'hB0B0_0002);

    // A lone requester is granted on consecutive cycles.
    wb0_valid = 1'b0;
    #1;
    grants("solo1_a", 1'b0, 1'b1);
    cyc();
    grants("solo1_b", 1'b0, 1'b1);
    cyc();
    wb1_valid = 1'b0;
    wb0_valid = 1'b1;
    #1;
    grants("solo0_a", 1'b1, 1'b0);
    cyc();
    grants("solo0_b", 1'b1, 1'b0);
    cyc();

    // Same-cycle clear and set of x7: set wins.
    idle_inputs();
    issue(5'd7, 5'd0, 5'd0);
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h0000_0777;
    #1;
    check("x7_issue_ready", 32'(issue_ready), 32'd1);
    grants("x7_wb", 1'b1, 1'b0);
    cyc();
    idle_inputs();
    issue(5'd8, 5'd0, 5'd7);
    #1;
    check("x7_set_wins_idle", 32'(idle), 32'd0);
    check("x7_set_wins_stall", 32'(issue_ready), 32'd0);
    issue_valid = 1'b0;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h0000_0007;
    cyc();
    idle_inputs();
    #1;
    check("x7_retired_idle", 32'(idle), 32'd1);

    // Writeback to x0 handshakes without a register write; issue to x0 never marks busy.
    wb1_valid = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h0000_1234;
    issue(5'd0, 5'd0, 5'd0);
    #1;
    grants("x0_wb", 1'b0, 1'b1);
    check("x0_rf_we", 32'(rf_we), 32'd0);
    check("x0_issue_ready", 32'(issue_ready), 32'd1);
    cyc();
    idle_inputs();
    #1;
    check("x0_rf_read", rf_mem[0], 32'd0);
    check("x0_idle", 32'(idle), 32'd1);

    // Reset mid-operation drops busy[3] and refuses the in-flight writeback.
    issue(5'd3, 5'd0, 5'd0);
    cyc();
    idle_inputs();
    #1;
    check("busy3_idle", 32'(idle), 32'd0);
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h3333_3333;
    #1;
    grants("rst_mid", 1'b0, 1'b0);
    check("rst_mid_rf_we", 32'(rf_we), 32'd0);
    cyc();
    rst = 1'b0;
    idle_inputs();
    issue(5'd9, 5'd3, 5'd0);
    #1;
    check("rst_mid_idle", 32'(idle), 32'd1);
    check("rst_mid_x3_free", 32'(issue_ready), 32'd1);
    check("rst_mid_rf_x3", rf_mem[3], 32'd0);
    cyc();
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/rf_wb_sched.md
RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 Parameters: none; widths SHALL come from the shared defines `RF_ADDR_WIDTH (5) and `WORD_WIDTH (32).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 issue_valid  in  1  decode issues an instruction that writes rd.
REQ-005 issue_rd / issue_rs1 / issue_rs2  in  5 each  destination and source register addresses of the issuing instruction.
REQ-006 issue_ready  out  1  issue accepted this cycle (no hazard).
REQ-007 wb0_valid, wb0_addr[5], wb0_data[32]  in  writeback requester 0 (ALU).
REQ-008 wb1_valid, wb1_addr[5], wb1_data[32]  in  writeback requester 1 (load unit).
REQ-009 wb0_ready, wb1_ready  out  1 each  grant; handshake completes when valid && ready.
REQ-010 rf_we  out  1  drives the RF regWrite port.
REQ-011 rf_waddr  out  5  drives the RF write_addr port.
REQ-012 rf_wdata  out  32  drives the RF data_in port.
REQ-013 idle  out  1  no register write pending.

Function
REQ-014 Block SHALL share the single RF write port between wb0 and wb1; at most one ready SHALL be high per cycle.
REQ-015 Arbitration SHALL be round-robin: single valid is granted; if both are valid, the requester not granted last is granted; last_grant updates only on a completed handshake.
REQ-016 Grant and rf_* outputs SHALL be combinational from the current valids and last_grant; the write lands at the same posedge the handshake completes (0-cycle latency).
REQ-017 rf_waddr/rf_wdata SHALL follow the granted requester; with no grant: rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-018 Writeback to x0 SHALL complete the handshake with rf_we=0.
REQ-019 Scoreboard: 32 busy bits; busy[0] hardwired 0.
REQ-020 Hazard: issue_ready = issue_valid && !busy[rs1] && !busy[rs2] && !busy[rd]; indices equal to 0 never stall.
REQ-021 An accepted issue with rd!=0 SHALL set busy[rd] at the next posedge.
REQ-022 A completed writeback with addr!=0 SHALL clear busy[addr] at the next posedge.
REQ-023 If set and clear target the same rd in one cycle, set SHALL win (busy stays 1).
REQ-024 Busy bits SHALL NOT be bypassed: a register being cleared this cycle still stalls issue this cycle.
REQ-025 A writeback to a register that is not busy SHALL still be written and granted normally (no error).
REQ-026 idle SHALL be 1 when all busy bits are 0 (combinational).

Reset
REQ-027 While rst=1 at posedge: all busy bits <= 0; last_grant <= 1, so wb0 wins the first contention.
REQ-028 While rst=1, wb0_ready, wb1_ready, rf_we and issue_ready SHALL be forced to 0; after reset, idle=1.
REQ-029 Reset mid-operation SHALL drop pending scoreboard state; writebacks in flight are not acknowledged.

Structure
REQ-030 Widths SHALL use the existing shared defines (`RF_ADDR_WIDTH, `WORD_WIDTH); the requester-ID enum (WB_ALU=0, WB_LSU=1) SHALL live in the shared common package.
REQ-031 The two-way round-robin arbiter SHALL be a sub-module rr_arb2 (req[1:0] -> gnt[1:0], last-grant register inside).
REQ-032 rf_wb_sched SHALL instantiate rr_arb2 and hold the scoreboard; the RF itself stays a separate instance.

Verification
REQ-033 Reset -> idle=1, all ready/rf_we=0; first cycle after with issue_valid, rd=5, rs1=0, rs2=0 -> issue_ready=1, busy[5]=1, idle=0.
REQ-034 busy[5]=1; issue rs1=5 -> issue_ready=0; wb0 valid addr=5 data=0xDEADBEEF -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; next cycle issue_ready=1.
REQ-035 wb0 and wb1 both valid for 4 cycles after reset -> grants 0,1,0,1; a single valid requester is granted every cycle.
REQ-036 Same cycle: writeback addr=7 completes and issue rd=7 accepted -> busy[7]=1 after the edge.
REQ-037 wb1 valid addr=0 data=0x1234 -> wb1_ready=1, rf_we=0; RF x0 reads 0.
REQ-038 rst asserted with busy[3]=1 and wb0 valid -> wb0_ready=0, rf_we=0; after the edge busy all 0 and idle=1.
